// File: rtl/pkt_filter.sv
// rtl/pkt_filter.sv - ingress packet classifier: control / data (gap-enforced) / drop; stats counters under PKT_FILTER_STATS_EN
module pkt_filter #(
    parameter int             C_S_AXIS_DATA_WIDTH  = 512,
    parameter int             C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0]    CTRL_UDP_PORT        = 16'hF1F2,
    parameter int             GAP_CYCLES           = 1,
    parameter int             REQUIRE_VLAN         = 1
) (
    input  logic                                  axis_clk,
    input  logic                                  axis_rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]      s_axis_tkeep,
    input  logic                                  s_axis_tvalid,
    input  logic                                  s_axis_tlast,
    output logic                                  s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]       m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]        c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]       c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]      c_m_axis_tkeep,
    output logic                                  c_m_axis_tvalid,
    output logic                                  c_m_axis_tlast,
    output logic [31:0]                           data_pkt_cnt,
    output logic [31:0]                           ctrl_pkt_cnt,
    output logic [31:0]                           drop_pkt_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FWD_DATA = 3'd1;
    localparam logic [2:0] S_FWD_CTRL = 3'd2;
    localparam logic [2:0] S_DROP     = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    localparam logic [1:0] C_DATA = 2'd0;
    localparam logic [1:0] C_CTRL = 2'd1;
    localparam logic [1:0] C_DROP = 2'd2;

    localparam logic       REQ_VLAN = (REQUIRE_VLAN != 0);
    // The slot hand-off cycle already counts as the first low cycle, so the
    // counter terminates one short of GAP_CYCLES.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [2:0] r_state;
    logic [3:0] r_gap_cnt;

    // Header fields of the first beat (byte n = tdata[8n+:8], byte 0 first).
    logic [15:0] w_tpid;
    logic [15:0] w_inner_type;
    logic [7:0]  w_ip_verlen;
    logic [7:0]  w_ip_proto;
    logic [15:0] w_udp_dport;
    logic        w_vlan;
    logic        w_ctrl;
    logic [1:0]  w_class;

    assign w_tpid       = {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]};
    assign w_inner_type = {s_axis_tdata[16*8 +: 8], s_axis_tdata[17*8 +: 8]};
    assign w_ip_verlen  = s_axis_tdata[18*8 +: 8];
    assign w_ip_proto   = s_axis_tdata[27*8 +: 8];
    assign w_udp_dport  = {s_axis_tdata[40*8 +: 8], s_axis_tdata[41*8 +: 8]};

    assign w_vlan  = (w_tpid == 16'h8100);
    assign w_ctrl  = w_vlan && (w_inner_type == 16'h0800) && (w_ip_verlen == 8'h45)
                     && (w_ip_proto == 8'h11) && (w_udp_dport == CTRL_UDP_PORT);
    assign w_class = w_ctrl ? C_CTRL : ((w_vlan || !REQ_VLAN) ? C_DATA : C_DROP);

    logic w_slot_free;
    logic w_s_hs;
    logic w_first;
    logic w_to_data;
    logic w_to_ctrl;

    assign w_slot_free = !m_axis_tvalid || m_axis_tready;

    // Ingress ready: only the data route is subject to downstream backpressure.
    always_comb begin
        s_axis_tready = 1'b0;
        case (r_state)
            S_IDLE:     s_axis_tready = (w_class == C_DATA) ? w_slot_free : 1'b1;
            S_FWD_DATA: s_axis_tready = w_slot_free;
            S_FWD_CTRL: s_axis_tready = 1'b1;
            S_DROP:     s_axis_tready = 1'b1;
            default:    s_axis_tready = 1'b0;
        endcase
        if (axis_rst) begin
            s_axis_tready = 1'b0;
        end
    end

    assign w_s_hs    = s_axis_tvalid && s_axis_tready;
    assign w_first   = w_s_hs && (r_state == S_IDLE);
    assign w_to_data = w_s_hs && (((r_state == S_IDLE) && (w_class == C_DATA)) || (r_state == S_FWD_DATA));
    assign w_to_ctrl = w_s_hs && (((r_state == S_IDLE) && (w_class == C_CTRL)) || (r_state == S_FWD_CTRL));

    // Packet FSM and inter-packet gap counter.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_first) begin
                        case (w_class)
                            C_DATA:  r_state <= s_axis_tlast ? S_GAP  : S_FWD_DATA;
                            C_CTRL:  r_state <= s_axis_tlast ? S_IDLE : S_FWD_CTRL;
                            default: r_state <= s_axis_tlast ? S_IDLE : S_DROP;
                        endcase
                    end
                end
                S_FWD_DATA: if (w_s_hs && s_axis_tlast) r_state <= S_GAP;
                S_FWD_CTRL: if (w_s_hs && s_axis_tlast) r_state <= S_IDLE;
                S_DROP:     if (w_s_hs && s_axis_tlast) r_state <= S_IDLE;
                S_GAP: begin
                    // Count only once the last data beat is leaving or gone.
                    if (w_slot_free) begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_gap_cnt <= 4'd0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One-deep data output slot; contents hold while stalled.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (w_to_data) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Control path: each accepted beat appears for exactly one cycle.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            c_m_axis_tvalid <= w_to_ctrl;
            if (w_to_ctrl) begin
                c_m_axis_tdata <= s_axis_tdata;
                c_m_axis_tuser <= s_axis_tuser;
                c_m_axis_tkeep <= s_axis_tkeep;
                c_m_axis_tlast <= s_axis_tlast;
            end
        end
    end

`ifdef PKT_FILTER_STATS_EN
    logic [31:0] r_data_cnt;
    logic [31:0] r_ctrl_cnt;
    logic [31:0] r_drop_cnt;

    // Per-class packet counters, bumped on the first-beat handshake.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_data_cnt <= 32'd0;
            r_ctrl_cnt <= 32'd0;
            r_drop_cnt <= 32'd0;
        end else if (w_first) begin
            case (w_class)
                C_DATA:  r_data_cnt <= r_data_cnt + 32'd1;
                C_CTRL:  r_ctrl_cnt <= r_ctrl_cnt + 32'd1;
                default: r_drop_cnt <= r_drop_cnt + 32'd1;
            endcase
        end
    end

    assign data_pkt_cnt = r_data_cnt;
    assign ctrl_pkt_cnt = r_ctrl_cnt;
    assign drop_pkt_cnt = r_drop_cnt;
`else
    assign data_pkt_cnt = 32'h0;
    assign ctrl_pkt_cnt = 32'h0;
    assign drop_pkt_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pkt_filter.sv
// tb/tb_pkt_filter.sv - scoreboard bench for pkt_filter
module tb_pkt_filter;

    localparam int GAP = 2;

    typedef struct {
        logic [511:0] d;
        logic [127:0] u;
        logic [63:0]  k;
        logic         l;
        int           acc;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] s_tdata;
    logic [127:0] s_tuser;
    logic [63:0]  s_tkeep;
    logic         s_tlast;
    logic         a_tvalid, b_tvalid;
    logic         a_tready, b_tready;
    logic         m_tready;

    logic [511:0] a_m_tdata, a_c_tdata, b_m_tdata, b_c_tdata;
    logic [127:0] a_m_tuser, a_c_tuser, b_m_tuser, b_c_tuser;
    logic [63:0]  a_m_tkeep, a_c_tkeep, b_m_tkeep, b_c_tkeep;
    logic         a_m_tvalid, a_m_tlast, a_c_tvalid, a_c_tlast;
    logic         b_m_tvalid, b_m_tlast, b_c_tvalid, b_c_tlast;
    logic [31:0]  a_dcnt, a_ccnt, a_xcnt, b_dcnt, b_ccnt, b_xcnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e_data = 0, e_ctrl = 0, e_drop = 0, e_bdata = 0;
    beat_t qa_d[$], qa_c[$], qb_d[$];

    bit  mon_en = 1'b1;
    bit  stall_en = 1'b0;
    logic [3:0] pat = 4'b1001;
    int  pidx = 0;
    bit  a_in_pkt = 0, a_seen = 0, prev_stall = 0;
    int  low_run = 0, last_gap = -1;
    logic [511:0] prev_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pkt_filter #(.GAP_CYCLES(GAP), .REQUIRE_VLAN(1)) u_a (
        .axis_clk(clk), .axis_rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(a_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(a_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tuser(a_m_tuser), .m_axis_tkeep(a_m_tkeep),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast), .m_axis_tready(m_tready),
        .c_m_axis_tdata(a_c_tdata), .c_m_axis_tuser(a_c_tuser), .c_m_axis_tkeep(a_c_tkeep),
        .c_m_axis_tvalid(a_c_tvalid), .c_m_axis_tlast(a_c_tlast),
        .data_pkt_cnt(a_dcnt), .ctrl_pkt_cnt(a_ccnt), .drop_pkt_cnt(a_xcnt)
    );

    pkt_filter #(.GAP_CYCLES(GAP), .REQUIRE_VLAN(0)) u_b (
        .axis_clk(clk), .axis_rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(b_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(b_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tuser(b_m_tuser), .m_axis_tkeep(b_m_tkeep),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast), .m_axis_tready(1'b1),
        .c_m_axis_tdata(b_c_tdata), .c_m_axis_tuser(b_c_tuser), .c_m_axis_tkeep(b_c_tkeep),
        .c_m_axis_tvalid(b_c_tvalid), .c_m_axis_tlast(b_c_tlast),
        .data_pkt_cnt(b_dcnt), .ctrl_pkt_cnt(b_ccnt), .drop_pkt_cnt(b_xcnt)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
`ifdef PKT_FILTER_STATS_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    function automatic logic [511:0] mk_hdr(input bit vlan, input logic [15:0] dport);
        logic [511:0] h;
        h = {64{8'hA5}};
        h[12*8 +: 8] = vlan ? 8'h81 : 8'h08;
        h[13*8 +: 8] = 8'h00;
        h[16*8 +: 8] = 8'h08;
        h[17*8 +: 8] = 8'h00;
        h[18*8 +: 8] = 8'h45;
        h[27*8 +: 8] = 8'h11;
        h[40*8 +: 8] = dport[15:8];
        h[41*8 +: 8] = dport[7:0];
        return h;
    endfunction

    // Downstream ready for DUT A: constant 1 or the 1,0,0,1 stall pattern.
    always @(posedge clk) begin
        #1;
        if (stall_en) begin
            m_tready = pat[3 - (pidx % 4)];
            pidx++;
        end else begin
            m_tready = 1'b1;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (a_m_tvalid && prev_stall) chk("a_hold_stable", a_m_tdata, prev_data);
            if (a_m_tvalid && !m_tready)  chk("s_tready_low_stalled", a_tready, 0);
            if (a_m_tvalid && m_tready) begin
                if (qa_d.size() == 0) chk("a_data_unexpected", 1, 0);
                else begin
                    e = qa_d.pop_front();
                    chk("a_data_tdata", a_m_tdata, e.d);
                    chk("a_data_tuser", a_m_tuser, e.u);
                    chk("a_data_tkeep", a_m_tkeep, e.k);
                    chk("a_data_tlast", a_m_tlast, e.l);
                end
            end
            if (a_m_tvalid) begin
                if (!a_in_pkt) begin
                    if (a_seen) last_gap = low_run;
                    a_in_pkt = 1;
                end
                if (m_tready && a_m_tlast) begin
                    a_in_pkt = 0;
                    a_seen = 1;
                    low_run = 0;
                end
            end else begin
                low_run++;
            end
            if (a_c_tvalid) begin
                if (qa_c.size() == 0) chk("a_ctrl_unexpected", 1, 0);
                else begin
                    e = qa_c.pop_front();
                    chk("a_ctrl_tdata", a_c_tdata, e.d);
                    chk("a_ctrl_tlast", a_c_tlast, e.l);
                    chk("a_ctrl_latency", cyc, e.acc + 1);
                end
            end
            if (b_m_tvalid) begin
                if (qb_d.size() == 0) chk("b_data_unexpected", 1, 0);
                else begin
                    e = qb_d.pop_front();
                    chk("b_data_tdata", b_m_tdata, e.d);
                    chk("b_data_tuser", b_m_tuser, e.u);
                    chk("b_data_tkeep", b_m_tkeep, e.k);
                    chk("b_data_tlast", b_m_tlast, e.l);
                end
            end
            if (b_c_tvalid) chk("b_ctrl_unexpected", {b_c_tlast, b_c_tkeep, b_c_tuser[0], b_c_tdata[0]}, 0);
        end
        prev_stall = a_m_tvalid && !m_tready;
        prev_data  = a_m_tdata;
    end

    // tgt 0 drives DUT A, 1 drives DUT B; cls: 0 data, 1 ctrl, 2 drop.
    task automatic send_beat(input int tgt, input int cls, input bit first, input logic [511:0] d,
                             input logic [127:0] u, input logic [63:0] k, input bit l, inout int stalls);
        bit hs;
        int t;
        beat_t e;
        s_tdata = d; s_tuser = u; s_tkeep = k; s_tlast = l;
        a_tvalid = (tgt == 0);
        b_tvalid = (tgt == 1);
        hs = 0;
        t = 0;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = (tgt == 0) ? a_tready : b_tready;
            if (hs) begin
                e.d = d; e.u = u; e.k = k; e.l = l; e.acc = cyc;
                if (tgt == 0 && cls == 0) qa_d.push_back(e);
                if (tgt == 0 && cls == 1) qa_c.push_back(e);
                if (tgt == 1 && cls == 0) qb_d.push_back(e);
                if (first && tgt == 0) begin
                    if (cls == 0) e_data++;
                    else if (cls == 1) e_ctrl++;
                    else e_drop++;
                end
                if (first && tgt == 1 && cls == 0) e_bdata++;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) chk("ingress_handshake_timeout", 0, 1);
    endtask

    task automatic send(input int tgt, input int cls, input int n, input logic [511:0] hdr,
                        input int id, output int stalls);
        logic [511:0] d;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? hdr : {16{16'(id), 16'(k)}};
            send_beat(tgt, cls, k == 0, d, {96'h0, 16'(id), 16'(k)},
                      (k == n - 1) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF,
                      k == n - 1, stalls);
        end
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa_d.size() + qa_c.size() + qb_d.size()) != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 0, 1);
        repeat (GAP + 4) @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_data_cnt"}, a_dcnt, cexp(e_data));
        chk({nm, "_ctrl_cnt"}, a_ccnt, cexp(e_ctrl));
        chk({nm, "_drop_cnt"}, a_xcnt, cexp(e_drop));
    endtask

    initial begin
        int st;
        rst = 1'b1;
        a_tvalid = 0; b_tvalid = 0; m_tready = 1;
        s_tdata = '0; s_tuser = '0; s_tkeep = '0; s_tlast = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", a_tready, 0);
        chk("rst_m_tvalid", a_m_tvalid, 0);
        chk("rst_c_tvalid", a_c_tvalid, 0);
        chk("rst_m_tdata", a_m_tdata, 0);
        chk_cnt("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Control packet, 3 beats.
        send(0, 1, 3, mk_hdr(1, 16'hF1F2), 1, st);
        drain();
        chk_cnt("ctrl");

        // Back-to-back data packets: 2 beats then 1 beat.
        send(0, 0, 2, mk_hdr(1, 16'h0035), 2, st);
        send(0, 0, 1, mk_hdr(1, 16'hF1F3), 3, st);
        drain();
        chk("data_gap_cycles", last_gap, GAP);
        chk_cnt("b2b");

        // Untagged: dropped by A (never stalled), forwarded by B.
        send(0, 2, 2, mk_hdr(0, 16'hF1F2), 4, st);
        drain();
        chk("drop_tready_stalls", st, 0);
        chk_cnt("drop");
        send(1, 0, 2, mk_hdr(0, 16'hF1F2), 4, st);
        drain();
        chk("b_data_cnt", b_dcnt, cexp(e_bdata));
        chk("b_drop_cnt", b_xcnt, 0);
        chk("b_ctrl_cnt", b_ccnt, 0);

        // Stalling downstream, 4-beat data packet.
        stall_en = 1'b1;
        send(0, 0, 4, mk_hdr(1, 16'h1234), 5, st);
        drain();
        stall_en = 1'b0;
        @(posedge clk); #1;
        chk_cnt("stall");

        // Reset on beat 2 of a 4-beat data packet.
        mon_en = 1'b0;
        st = 0;
        send_beat(0, 0, 1, mk_hdr(1, 16'h0035), 128'h6_0000, '1, 0, st);
        send_beat(0, 0, 0, {16{32'h0006_0001}}, 128'h6_0001, '1, 0, st);
        s_tdata = {16{32'h0006_0002}};
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_tvalid", a_m_tvalid, 0);
        chk("midrst_s_tready", a_tready, 0);
        e_data = 0; e_ctrl = 0; e_drop = 0;
        chk_cnt("midrst");
        rst = 1'b0;
        a_tvalid = 1'b0;
        qa_d.delete(); qa_c.delete(); qb_d.delete();
        a_in_pkt = 0; a_seen = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        send(0, 1, 2, mk_hdr(1, 16'hF1F2), 7, st);
        drain();
        chk_cnt("postrst");

        chk("end_qa_d_empty", qa_d.size(), 0);
        chk("end_qa_c_empty", qa_c.size(), 0);
        chk("end_qb_d_empty", qb_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_filter.md
Name: pkt_filter

Overview:
- Ingress stage that sits directly upstream of the parser.
- Takes the 512b AXI-Stream from the 100G MAC and classifies each packet on its first beat.
- Classes: control (module-config packets), data, or drop.
- Control packets go to the parser's control path (no backpressure). Data packets go to the parser's data input with guaranteed idle gaps between packets, because the parser detects a packet start from a tvalid rising edge.

Parameters:
C_S_AXIS_DATA_WIDTH, 512, AXIS data width; only 512 supported.
C_S_AXIS_TUSER_WIDTH, 128, AXIS tuser width.
CTRL_UDP_PORT, 16'hF1F2, UDP destination port that marks a control packet.
GAP_CYCLES, 1, minimum idle cycles on m_axis_tvalid between data packets (1..15).
REQUIRE_VLAN, 1, 1 = untagged packets are dropped; 0 = untagged packets are forwarded as data.

Ports:
axis_clk  in  1  clock
axis_rst  in  1  synchronous active-high reset
s_axis_tdata  in  512  ingress data; byte n = tdata[8n+:8], byte 0 first on wire
s_axis_tuser  in  128  ingress sideband
s_axis_tkeep  in  64  ingress byte enables
s_axis_tvalid  in  1  ingress valid
s_axis_tlast  in  1  ingress last beat
s_axis_tready  out  1  ingress ready
m_axis_tdata/tuser/tkeep  out  512/128/64  data path to parser
m_axis_tvalid  out  1  data valid
m_axis_tlast  out  1  data last beat
m_axis_tready  in  1  data ready
c_m_axis_tdata/tuser/tkeep  out  512/128/64  control path to parser
c_m_axis_tvalid  out  1  control valid (no ready)
c_m_axis_tlast  out  1  control last beat
data_pkt_cnt  out  32  data packets forwarded
ctrl_pkt_cnt  out  32  control packets forwarded
drop_pkt_cnt  out  32  packets dropped

Behaviour:
- Reset: all outputs 0, s_axis_tready 0 during reset, FSM = IDLE, gap counter 0.
- Classification is combinational on the first beat while in IDLE.
  - vlan = {b12,b13}==16'h8100
  - ctrl = vlan & {b16,b17}==16'h0800 & b18==8'h45 & b27==8'h11 & {b40,b41}==CTRL_UDP_PORT
  - class = ctrl ? CTRL : (vlan | ~REQUIRE_VLAN) ? DATA : DROP
- FSM states: IDLE, FWD_DATA, FWD_CTRL, DROP, GAP.
- IDLE
  - s_axis_tready = (class==DATA) ? data_slot_free : 1.
  - On first-beat handshake the beat is routed by class.
  - Next state: tlast set → GAP (DATA) or IDLE (CTRL/DROP); tlast clear → FWD_DATA / FWD_CTRL / DROP.
- Data output is a 1-deep registered slot.
  - data_slot_free = ~m_axis_tvalid | m_axis_tready.
  - Slot loads on every input handshake routed to data; latency 1 cycle.
  - m_axis_tvalid clears on an output handshake with no new load.
  - tdata/tuser/tkeep/tlast hold stable while tvalid=1 and tready=0.
- FWD_DATA: s_axis_tready = data_slot_free. Accepted tlast → GAP.
- FWD_CTRL
  - s_axis_tready = 1.
  - Each accepted beat is registered onto c_m_axis_*, with c_m_axis_tvalid high for exactly that one cycle (latency 1).
  - Accepted tlast → IDLE.
- DROP: s_axis_tready = 1, beats discarded. Accepted tlast → IDLE.
- GAP
  - s_axis_tready = 0.
  - First wait until the final data beat has left the slot (its output handshake).
  - Then count GAP_CYCLES cycles with m_axis_tvalid=0, then → IDLE.
  - Guarantees ≥GAP_CYCLES low cycles on m_axis_tvalid between data packets.
- Control packets need no gap; back-to-back control packets are allowed.
- Counters
  - Increment once per packet on the first-beat handshake, according to class.
  - 32b, wrap to 0 after 32'hFFFFFFFF.
- A single-beat packet (tlast on first beat) is handled as listed under IDLE.
- s_axis_tvalid dropping mid-packet: state held, no output produced until valid returns.
- Reset mid-packet: immediate return to IDLE with outputs cleared. Upstream is reset on the same axis_rst, so no partial packet follows.
- tkeep is passed through unmodified; classification does not inspect tkeep.

Optional Feature:
- Macro: PKT_FILTER_STATS_EN.
- Defined: data_pkt_cnt, ctrl_pkt_cnt and drop_pkt_cnt are implemented as specified above.
- Undefined: counter logic is not built and the three ports are tied to 32'h0.
- Forwarding behaviour is identical either way.

Test Plan:
- VLAN-tagged IPv4/UDP packet, dport 0xF1F2, 3 beats, m_axis_tready=1 → 3 single-cycle c_m_axis_tvalid pulses, tlast on the 3rd, each 1 cycle after input; m_axis_tvalid stays 0; ctrl_pkt_cnt=1.
- Two back-to-back VLAN data packets (2 beats, then 1 beat, no input idle), GAP_CYCLES=2, tready=1 → m_axis carries beats 1,2, then exactly 2 cycles tvalid=0, then the 1-beat packet; data_pkt_cnt=2.
- Untagged packet with REQUIRE_VLAN=1 → s_axis_tready=1 throughout, no output on either port, drop_pkt_cnt=1; same stimulus with REQUIRE_VLAN=0 → forwarded on m_axis.
- VLAN data packet of 4 beats with m_axis_tready toggling 1,0,0,1,... → no beat lost or duplicated, m_axis_tdata stable while stalled, s_axis_tready low while the slot is full and stalled.
- axis_rst asserted on beat 2 of a 4-beat data packet → next cycle m_axis_tvalid=0 and counters=0; a fresh control packet after reset is classified correctly.
- Build with PKT_FILTER_STATS_EN undefined, send one packet of each class → all counters read 32'h0, forwarding unchanged.
